// File: rtl/sort_seq.sv
// Sequential bubble sorter: N 4-bit unsigned elements, sorted in place
// in ascending order. All pairs are compared on one shared magnitude
// comparator, at one comparison per clock.

// 4-bit unsigned magnitude comparator: y=1 iff a>b.
module strongmore (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       y
);
  assign y = (a > b);
endmodule

module sort_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [4*N-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] dout,
  output logic [5:0]     swap_cnt
);
  localparam int IW = (N <= 2) ? 1 : $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 2);
  localparam logic [2:0]    PMAX = 3'(N - 2);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t              state, nxt;
  logic [N-1:0][3:0]   r;
  logic [IW-1:0]       idx, idx1;
  logic [2:0]          pass;
  logic                swapped;
  logic                y;
  logic                last;
  logic                cont;

  assign idx1 = idx + 1'b1;
  assign last = (idx == LAST);
  // Another pass is needed only if the pass now ending swapped something
  // (including the swap in this cycle) and the pass limit is not reached.
  assign cont = (pass < PMAX) && (swapped || y);

  strongmore u_cmp (
    .a (r[idx]),
    .b (r[idx1]),
    .y (y)
  );

  assign dout = r;
  assign busy = (state == CMP);
  assign done = (state == DONE);

  // State register; reset wins in every state.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = CMP;
      CMP:     if (last && !cont) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Element registers, pass/index counters, and swap bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r        <= '0;
      swap_cnt <= '0;
      idx      <= '0;
      pass     <= '0;
      swapped  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r        <= din;
            swap_cnt <= '0;
            idx      <= '0;
            pass     <= '0;
            swapped  <= 1'b0;
          end
        end
        CMP: begin
          // Strict greater-than only, so equal keys keep their order.
          if (y) begin
            r[idx]   <= r[idx1];
            r[idx1]  <= r[idx];
            swapped  <= 1'b1;
            swap_cnt <= swap_cnt + 6'd1;
          end
          if (!last) begin
            idx <= idx1;
          end else if (cont) begin
            // This assignment overrides the set above: the new pass starts clean.
            idx     <= '0;
            pass    <= pass + 3'd1;
            swapped <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sort_seq.md
Name: sort_seq

Overview:
- Sequential bubble sorter for N 4-bit unsigned elements.
- Shares one `strongmore` 4-bit magnitude comparator (y=1 iff a>b, unsigned) across all element pairs, one comparison per cycle.
- Accepts a packed vector on a start pulse, sorts it in place in ascending order, then pulses done.
- Serves as the sequencing/control layer that reuses the single comparator datapath instead of replicating it.

Parameters:
- N, default 4: element count, legal range 2..8. Element width is fixed at 4 bits by the comparator.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  load din and begin sorting; sampled only in IDLE.
- din  input  4*N  packed elements; element i = din[4i+3:4i].
- busy  output  1  high while in CMP state.
- done  output  1  single-cycle pulse when the sort completes.
- dout  output  4*N  element registers, packed like din; ascending, so element 0 is the smallest.
- swap_cnt  output  6  number of swaps performed in the current/last sort.

Behaviour:
- Storage: N 4-bit element regs r[0..N-1]; dout = regs directly. Also pass counter, index counter idx, swapped flag, swap_cnt.
- Comparator: exactly one `strongmore` instance; a=r[idx], b=r[idx+1]; no other magnitude compare logic.
- Reset (synchronous, takes priority in every state including mid-sort):
  - state=IDLE.
  - all r=0, swap_cnt=0, busy=0, done=0, idx=0, pass=0, swapped=0.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1 at an edge: r[i]<=din element i, swap_cnt<=0, idx<=0, pass<=0, swapped<=0, go to CMP.
  - start=0: hold everything; dout keeps the last result.
- CMP (busy=1), one compare per cycle:
  - If y=1: swap r[idx] and r[idx+1], swapped<=1, swap_cnt++.
  - Equal elements are never swapped, so the sort is stable.
  - idx<N-2: idx++.
  - idx==N-2 (end of pass): if pass<N-2 and (swapped or this cycle's y)=1, then idx<=0, pass++, swapped<=0, stay in CMP; otherwise go to DONE.
  - Early exit: a pass with zero swaps ends the sort. At most N-1 passes are performed.
  - start is ignored while busy; din is not resampled.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - dout and swap_cnt are final from this cycle until the next accepted start.
  - start asserted during DONE is ignored.
- Latency: start sampled at edge E0; CMP occupies C cycles; done is high in the cycle after edge E0+C.
  - Min C = N-1 (already sorted input).
  - Max C = (N-1)^2.
- swap_cnt maximum is N(N-1)/2 = 28 for N=8; 6 bits never overflows.
- A back-to-back start is accepted no earlier than the first IDLE cycle after DONE.

Test Plan:
- N=4, din=16'h4321 (e0..e3 = 1,2,3,4), start pulse -> 3 busy cycles; done in the 4th cycle after the start edge; dout=16'h4321; swap_cnt=0.
- din=16'h0123 (e0..e3 = 3,2,1,0) -> 9 busy cycles; done; dout=16'h3210; swap_cnt=6.
- din=16'h0769 (e0..e3 = 9,6,7,0) -> comparisons per pass: (9,6) swap, (9,7) swap, (9,0) swap | (7,0) swap | (6,0) swap. Result: 9 busy cycles; dout=16'h9760; swap_cnt=5.
- din=16'h5555 -> no swaps; 3 busy cycles; dout=16'h5555; swap_cnt=0. Also din=16'hFF00 -> dout=16'hFF00 (exercises the 4'b1111 boundary).
- Start din=16'h0123; pulse start again with din=16'hAAAA in the 2nd busy cycle -> ignored; final dout=16'h3210.
- Start din=16'h0123; assert reset in the 5th busy cycle -> next cycle busy=0, done=0, dout=0, swap_cnt=0, state IDLE. A following start with 16'h4321 sorts normally.
